// File: rtl/ng_probe_pkg.sv
// Shared FSM encoding, control codes and module-header layout
// for the probe packet generator.
package ng_probe_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PASS_HDR,
    S_PASS_BODY,
    S_TX_HDR,
    S_TX_SEQ,
    S_TX_FILL
  } state_t;

  localparam logic [7:0] CTRL_MODULE_HDR = 8'hff;
  localparam logic [7:0] CTRL_LAST_FULL  = 8'h01;

  localparam int HDR_DST_LSB  = 48;
  localparam int HDR_WLEN_LSB = 32;
  localparam int HDR_BLEN_LSB = 0;

  function automatic logic [63:0] mod_hdr(
    input logic [15:0] dst,
    input logic [15:0] words
  );
    logic [63:0] h;
    h = '0;
    h[HDR_DST_LSB +: 16]  = dst;
    h[HDR_WLEN_LSB +: 16] = words;
    h[HDR_BLEN_LSB +: 16] = {words[12:0], 3'b000};
    return h;
  endfunction

endpackage

// File: rtl/small_fifo.sv
// First-word-fall-through FIFO; dout is valid whenever empty is low.
// nearly_full rises one entry before full.
module small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] FULL_CNT =
    {1'b1, {MAX_DEPTH_BITS{1'b0}}};
  localparam logic [MAX_DEPTH_BITS:0] NF_CNT = FULL_CNT - 1'b1;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   count;
  logic                      full;
  logic                      do_wr;
  logic                      do_rd;

  assign full        = count == FULL_CNT;
  assign nearly_full = count >= NF_CNT;
  assign empty       = count == '0;
  assign do_wr       = wr_en && !full;
  assign do_rd       = rd_en && !empty;
  assign dout        = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/probe_pkt_gen.sv
// Injects timed probe bursts between passthrough packets
// on the user data path.
module probe_pkt_gen
  import ng_probe_pkg::*;
#(
  parameter int DATA_WIDTH        = 64,
  parameter int CTRL_WIDTH        = 8,
  parameter int TS_WIDTH          = 32,
  parameter int MIN_PAYLOAD_WORDS = 2,
  parameter int FIFO_DEPTH_BITS   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  cfg_start,
  input  logic [15:0]           cfg_num_pkts,
  input  logic [15:0]           cfg_gap,
  input  logic [7:0]            cfg_payload_words,
  input  logic [15:0]           cfg_dst_port,
  output logic                  busy,
  output logic [15:0]           sent_count,
  output logic [TS_WIDTH-1:0]   timestamp
);

  localparam int FW = CTRL_WIDTH + DATA_WIDTH;

  state_t                state;
  state_t                state_nxt;
  logic [FW-1:0]         fifo_dout;
  logic [CTRL_WIDTH-1:0] fwd_ctrl;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic                  fifo_empty;
  logic                  fifo_nf;
  logic                  fifo_rd;
  logic [15:0]           remaining;
  logic [15:0]           gap_cnt;
  logic [15:0]           gap_r;
  logic [15:0]           dst_r;
  logic [7:0]            len_r;
  logic [7:0]            len_in;
  logic [7:0]            fill_left;
  logic [TS_WIDTH-1:0]   ts_snap;
  logic                  probe_due;
  logic                  pass_sel;
  logic                  fwd_ok;
  logic                  last_fill;
  logic                  fire;

  small_fifo #(
    .WIDTH          (FW),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .din         ({in_ctrl, in_data}),
    .wr_en       (in_wr),
    .rd_en       (fifo_rd),
    .dout        (fifo_dout),
    .nearly_full (fifo_nf),
    .empty       (fifo_empty)
  );

  assign in_rdy = !fifo_nf;
  assign {fwd_ctrl, fwd_data} = fifo_dout;

  assign probe_due = busy && remaining != '0
                  && gap_cnt == '0;
  assign pass_sel  = (state == S_IDLE && !probe_due)
                  || state == S_PASS_HDR
                  || state == S_PASS_BODY;
  assign fwd_ok    = pass_sel && !fifo_empty && out_rdy;
  assign last_fill = fill_left == 8'd1;
  assign fire      = cfg_start && !busy;

  assign len_in =
    (cfg_payload_words < 8'(MIN_PAYLOAD_WORDS))
      ? 8'(MIN_PAYLOAD_WORDS) : cfg_payload_words;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (probe_due)
          state_nxt = S_TX_HDR;
        else if (fwd_ok && fwd_ctrl == CTRL_WIDTH'(CTRL_MODULE_HDR))
          state_nxt = S_PASS_HDR;
      end
      S_PASS_HDR:
        if (fwd_ok && fwd_ctrl == '0) state_nxt = S_PASS_BODY;
      S_PASS_BODY:
        if (fwd_ok && fwd_ctrl != '0) state_nxt = S_IDLE;
      S_TX_HDR:
        if (out_rdy) state_nxt = S_TX_SEQ;
      S_TX_SEQ:
        if (out_rdy) state_nxt = S_TX_FILL;
      S_TX_FILL:
        if (out_rdy && last_fill) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    out_wr   = 1'b0;
    fifo_rd  = 1'b0;
    out_ctrl = '0;
    out_data = '0;
    unique case (1'b1)
      pass_sel: begin
        out_wr   = fwd_ok;
        fifo_rd  = fwd_ok;
        out_ctrl = fwd_ctrl;
        out_data = fwd_data;
      end
      state == S_TX_HDR: begin
        out_wr   = out_rdy;
        out_ctrl = CTRL_WIDTH'(CTRL_MODULE_HDR);
        out_data = DATA_WIDTH'(mod_hdr(dst_r, {8'h00, len_r}));
      end
      state == S_TX_SEQ: begin
        out_wr   = out_rdy;
        out_data = DATA_WIDTH'({sent_count, 16'h0, 32'(ts_snap)});
      end
      state == S_TX_FILL: begin
        out_wr = out_rdy;
        if (last_fill) out_ctrl = CTRL_WIDTH'(CTRL_LAST_FULL);
      end
      default: ;
    endcase
  end

  // The IDLE turnaround cycle is itself one gap clock, hence gap-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timestamp  <= '0;
      busy       <= 1'b0;
      sent_count <= '0;
      remaining  <= '0;
      gap_cnt    <= '0;
      gap_r      <= '0;
      dst_r      <= '0;
      len_r      <= '0;
      fill_left  <= '0;
      ts_snap    <= '0;
    end else begin
      timestamp <= timestamp + 1'b1;
      if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      if (fire) begin
        busy       <= cfg_num_pkts != '0;
        remaining  <= cfg_num_pkts;
        sent_count <= '0;
        gap_cnt    <= '0;
        gap_r      <= cfg_gap;
        dst_r      <= cfg_dst_port;
        len_r      <= len_in;
      end
      if (state == S_TX_HDR && out_rdy) ts_snap <= timestamp;
      if (state == S_TX_SEQ && out_rdy) fill_left <= len_r - 1'b1;
      if (state == S_TX_FILL && out_rdy) begin
        fill_left <= fill_left - 1'b1;
        if (last_fill) begin
          remaining  <= remaining - 1'b1;
          sent_count <= sent_count + 1'b1;
          gap_cnt    <= (gap_r == '0) ? '0 : gap_r - 1'b1;
          if (remaining == 16'd1) busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_probe_pkt_gen.sv
// Directed/randomized bench for probe_pkt_gen with a
// word-stream reference model and its own timestamp model.
module tb_probe_pkt_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        cfg_start;
  logic [15:0] cfg_num_pkts;
  logic [15:0] cfg_gap;
  logic [7:0]  cfg_payload_words;
  logic [15:0] cfg_dst_port;
  logic        busy;
  logic [15:0] sent_count;
  logic [31:0] timestamp;

  probe_pkt_gen dut (
    .clk               (clk),
    .reset             (reset),
    .in_data           (in_data),
    .in_ctrl           (in_ctrl),
    .in_wr             (in_wr),
    .in_rdy            (in_rdy),
    .out_data          (out_data),
    .out_ctrl          (out_ctrl),
    .out_wr            (out_wr),
    .out_rdy           (out_rdy),
    .cfg_start         (cfg_start),
    .cfg_num_pkts      (cfg_num_pkts),
    .cfg_gap           (cfg_gap),
    .cfg_payload_words (cfg_payload_words),
    .cfg_dst_port      (cfg_dst_port),
    .busy              (busy),
    .sent_count        (sent_count),
    .timestamp         (timestamp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ctrl;
    logic [63:0] data;
    logic [31:0] ts;
    int          cyc;
  } mon_t;

  typedef struct {
    logic [7:0]  ctrl;
    logic [63:0] data;
    bit          is_seq;
    logic [15:0] seq;
  } exp_t;

  mon_t        mon_q[$];
  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          bad_wr = 0;
  int          rdy_low = 0;
  logic [31:0] model_ts;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) model_ts <= 32'h0;
    else        model_ts <= model_ts + 32'h1;
  end

  always @(negedge clk) begin
    if (reset) begin
      if (out_wr) mon_q.push_back('{out_ctrl, out_data, model_ts, cyc});
      if (out_wr && !out_rdy) bad_wr++;
      if (!in_rdy) rdy_low++;
    end
  end

  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: a probe is header, sequence word, then L-1 fill words.
  task automatic add_probe(input logic [15:0] dst, input int pl,
                           input int seq);
    int L;
    L = (pl < 2) ? 2 : pl;
    exp_q.push_back('{8'hff, {dst, 16'(L), 16'h0, 16'(L * 8)}, 1'b0, 16'h0});
    exp_q.push_back('{8'h00, 64'h0, 1'b1, 16'(seq)});
    for (int i = 1; i < L; i++)
      exp_q.push_back('{(i == L - 1) ? 8'h01 : 8'h00, 64'h0, 1'b0, 16'h0});
  endtask

  task automatic write_word(input logic [7:0] c, output int wcyc);
    logic [63:0] d;
    d = {$urandom, $urandom};
    @(posedge clk); #1;
    in_wr = 1'b1; in_ctrl = c; in_data = d;
    wcyc = cyc;
    exp_q.push_back('{c, d, 1'b0, 16'h0});
    @(posedge clk); #1;
    in_wr = 1'b0;
  endtask

  task automatic write_run(input logic [7:0] c, output int wcyc);
    logic [63:0] d;
    d = {$urandom, $urandom};
    in_wr = 1'b1; in_ctrl = c; in_data = d;
    wcyc = cyc;
    exp_q.push_back('{c, d, 1'b0, 16'h0});
    @(posedge clk); #1;
  endtask

  task automatic start_burst(input int n, input int g, input int pl,
                             input logic [15:0] dst);
    @(posedge clk); #1;
    cfg_num_pkts = 16'(n); cfg_gap = 16'(g);
    cfg_payload_words = 8'(pl); cfg_dst_port = dst;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit bp);
    int quiet;
    quiet = 0;
    for (int i = 0; i < 3000 && quiet < 20; i++) begin
      @(posedge clk); #1;
      if (bp) out_rdy = ~out_rdy;
      @(negedge clk);
      if (!busy && !out_wr) quiet++;
      else quiet = 0;
    end
    out_rdy = 1'b1;
    chk({tag, "_timeout"}, 72'(quiet >= 20), 72'(1));
  endtask

  task automatic compare_stream(input string tag);
    int n;
    logic [63:0] ed;
    chk({tag, "_len"}, 72'(mon_q.size()), 72'(exp_q.size()));
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      ed = exp_q[i].data;
      if (exp_q[i].is_seq && i > 0)
        ed = {exp_q[i].seq, 16'h0, mon_q[i - 1].ts};
      chk($sformatf("%s_w%0d", tag, i),
          {mon_q[i].ctrl, mon_q[i].data}, {exp_q[i].ctrl, ed});
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int wc;
    int w0;
    int snap;
    int pl;
    logic [15:0] dst;

    reset = 1'b0; in_wr = 1'b0; in_ctrl = '0; in_data = '0;
    out_rdy = 1'b1; cfg_start = 1'b0; cfg_num_pkts = '0;
    cfg_gap = '0; cfg_payload_words = '0; cfg_dst_port = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_sent", 72'(sent_count), 72'(0));
    chk("rst_ts", 72'(timestamp), 72'(0));
    chk("rst_out_wr", 72'(out_wr), 72'(0));
    chk("rst_in_rdy", 72'(in_rdy), 72'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("ts_run", 72'(timestamp), 72'(model_ts));

    // Burst of three probes with a 10-clock gap.
    start_burst(3, 10, 4, 16'h0004);
    for (int k = 0; k < 3; k++) add_probe(16'h0004, 4, k);
    wait_done("burst", 1'b0);
    for (int k = 0; k < 2; k++)
      if (mon_q.size() >= 15)
        chk($sformatf("burst_gap%0d", k),
            72'(mon_q[5 * k + 5].cyc - mon_q[5 * k + 4].cyc), 72'(11));
    chk("burst_sent", 72'(sent_count), 72'(3));
    chk("burst_busy", 72'(busy), 72'(0));
    compare_stream("burst");

    // Passthrough only.
    snap = rdy_low;
    write_run(8'hff, w0);
    write_run(8'h00, wc);
    write_run(8'h00, wc);
    write_run(8'h40, wc);
    in_wr = 1'b0;
    wait_done("pass", 1'b0);
    if (mon_q.size() > 0)
      chk("pass_lat", 72'(mon_q[0].cyc), 72'(w0 + 1));
    chk("pass_in_rdy", 72'(rdy_low - snap), 72'(0));
    compare_stream("pass");

    // Probe becomes due while a packet sits in its body.
    write_word(8'hff, wc);
    write_word(8'h00, wc);
    write_word(8'h00, wc);
    repeat (3) @(posedge clk);
    pl = int'($urandom_range(2, 5));
    start_burst(1, 0, pl, 16'h0010);
    repeat (5) @(posedge clk);
    write_word(8'h00, wc);
    write_word(8'h00, wc);
    write_word(8'h40, wc);
    add_probe(16'h0010, pl, 0);
    wait_done("coll", 1'b0);
    compare_stream("coll");

    // Backpressure with out_rdy toggling every cycle.
    snap = bad_wr;
    pl = int'($urandom_range(2, 6));
    dst = 16'h1 << $urandom_range(0, 15);
    start_burst(2, 3, pl, dst);
    add_probe(dst, pl, 0);
    add_probe(dst, pl, 1);
    wait_done("bp", 1'b1);
    chk("bp_wr_gated", 72'(bad_wr - snap), 72'(0));
    chk("bp_sent", 72'(sent_count), 72'(2));
    compare_stream("bp");

    // Zero payload clamps to the minimum length.
    start_burst(1, 0, 0, 16'h0002);
    add_probe(16'h0002, 0, 0);
    wait_done("pl0", 1'b0);
    compare_stream("pl0");

    // A start pulse during a burst must be ignored.
    start_burst(2, 20, 2, 16'h0001);
    add_probe(16'h0001, 2, 0);
    add_probe(16'h0001, 2, 1);
    wc = 0;
    for (int i = 0; i < 500 && sent_count != 16'd1; i++) begin
      @(negedge clk);
      wc = i;
    end
    chk("ign_wait", 72'(sent_count), 72'(1));
    start_burst(5, 0, 3, 16'h0008);
    @(negedge clk);
    chk("ign_cnt", 72'(sent_count), 72'(1));
    chk("ign_busy", 72'(busy), 72'(1));
    wait_done("ign", 1'b0);
    chk("ign_sent", 72'(sent_count), 72'(2));
    compare_stream("ign");

    // Zero probe count never raises busy.
    start_burst(0, 0, 3, 16'h0001);
    @(negedge clk);
    chk("num0_busy_a", 72'(busy), 72'(0));
    repeat (5) @(negedge clk);
    chk("num0_busy_b", 72'(busy), 72'(0));
    chk("num0_sent", 72'(sent_count), 72'(0));
    chk("num0_words", 72'(mon_q.size()), 72'(0));

    // Reset in the middle of the fill words.
    start_burst(1, 0, 8, 16'h0001);
    for (int i = 0; i < 200 && mon_q.size() < 4; i++)
      @(negedge clk);
    chk("rstfill_reach", 72'(mon_q.size()), 72'(4));
    #1 reset = 1'b0;
    #1;
    chk("rstfill_out_wr", 72'(out_wr), 72'(0));
    chk("rstfill_busy", 72'(busy), 72'(0));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstfill_ts", 72'(timestamp), 72'(0));
    chk("rstfill_sent", 72'(sent_count), 72'(0));
    mon_q.delete();
    exp_q.delete();
    repeat (10) @(negedge clk);
    chk("rstfill_quiet", 72'(mon_q.size()), 72'(0));
    chk("ts_end", 72'(timestamp), 72'(model_ts));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
